vga_scan_ctrl: RTL and testbench

//  Display-side end of the pixel interface used by every screen renderer (title, game, success and fail backgrounds).

---
 rtl/vga_scan_ctrl.sv | 110 +++++++++++
 tb/tb_vga_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator: drives pixel coordinates to the renderers and
// registers their returned colour together with HSYNC/VSYNC one pixel later.
module vga_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        req_valid,
  input  logic [11:0] color,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             pix_en;
  logic             visible;
  logic             h_sync_on;
  logic             v_sync_on;
  logic             frame_end;

  always_comb begin
    pix_en    = (div_cnt == DIV_LAST);
    visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    h_sync_on = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    v_sync_on = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

  // Renderers only ever see in-range coordinates; blanking forces them to 0.
  always_comb begin
    x         = visible ? h_cnt : '0;
    y         = visible ? v_cnt[8:0] : '0;
    req_valid = visible;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // RGB and both syncs are taken from the same counter state, keeping them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        {vga_r, vga_g, vga_b} <= visible ? color : '0;
        vga_hs <= h_sync_on ? SYNC_POL : ~SYNC_POL;
        vga_vs <= v_sync_on ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunken raster so several whole frames fit in a short run;
// expectations come from absolute clock counts since reset release.
module tb_vga_scan_ctrl;

  localparam int CD    = 3;
  localparam int HV    = 24;
  localparam int HF    = 4;
  localparam int HS    = 6;
  localparam int HB    = 6;
  localparam int VV    = 16;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int HT    = HV + HF + HS + HB;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        req_valid;
  logic [11:0] color;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_start;

  int          checks = 0;
  int          errors = 0;
  int          mode;          // 0 random colour, 1 coordinate echo, 2 solid white
  logic [11:0] rand_color;
  bit          chk_en;

  vga_scan_ctrl #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .req_valid(req_valid),
    .color(color), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign color = (mode == 1) ? {x[3:0], y[3:0], 4'hA} :
                 (mode == 2) ? 12'hFFF : rand_color;

  always @(negedge clk) rand_color = 12'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: n = clock edges since reset release; pixel p = n / CD.
  int          n;
  logic [11:0] m_rgb;
  logic        m_hs, m_vs, m_fs;

  function automatic logic [11:0] want_color(input int h, input int v);
    case (mode)
      1:       return {4'(h), 4'(v), 4'hA};
      2:       return 12'hFFF;
      default: return rand_color;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1; m_fs = 1'b0;
    end else begin
      int p, h, v;
      m_fs = 1'b0;
      if (n % CD == CD - 1) begin
        p = n / CD;
        h = p % HT;
        v = (p / HT) % VT;
        m_rgb = (h < HV && v < VV) ? want_color(h, v) : 12'h000;
        m_hs  = !(h >= HV + HF && h < HV + HF + HS);
        m_vs  = !(v >= VV + VF && v < VV + VF + VS);
        m_fs  = (p % FRAME) == FRAME - 1;
      end
      n++;
    end
  end

  function automatic int cur_h();
    return (n / CD) % HT;
  endfunction

  function automatic int cur_v();
    return ((n / CD) / HT) % VT;
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int h, v;
      bit vis;
      h = cur_h();
      v = cur_v();
      vis = (h < HV) && (v < VV);
      check("x", 32'(x), vis ? 32'(h) : 32'd0);
      check("y", 32'(y), vis ? 32'(v) : 32'd0);
      check("req_valid", 32'(req_valid), 32'(vis));
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_rgb));
      check("hs", 32'(vga_hs), 32'(m_hs));
      check("vs", 32'(vga_vs), 32'(m_vs));
      check("frame_start", 32'(frame_start), 32'(m_fs));
    end
  end

  // Pulse widths and frame period measured directly from the output waveforms.
  int  hs_run, vs_run, clk_cnt, fs_last;
  bit  fs_seen;

  always @(negedge clk) begin
    clk_cnt++;
    if (!rst_n) begin
      hs_run = 0; vs_run = 0; fs_seen = 0;
    end else begin
      if (vga_hs == 1'b0) hs_run++;
      else if (hs_run != 0) begin
        check("hs_width", 32'(hs_run), 32'(HS * CD));
        hs_run = 0;
      end
      if (vga_vs == 1'b0) vs_run++;
      else if (vs_run != 0) begin
        check("vs_width", 32'(vs_run), 32'(VS * HT * CD));
        vs_run = 0;
      end
      if (frame_start) begin
        if (fs_seen) check("frame_period", 32'(clk_cnt - fs_last), 32'(FRAME * CD));
        fs_last = clk_cnt;
        fs_seen = 1;
      end
    end
  end

  initial begin
    bit found;
    rst_n  = 1'b0;
    mode   = 0;
    chk_en = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1;

    repeat (FRAME * CD + 200) @(negedge clk);
    mode = 1;
    repeat (FRAME * CD) @(negedge clk);
    mode = 2;
    repeat (FRAME * CD) @(negedge clk);
    mode = 0;

    // Reset in the middle of a visible line's sync pulse.
    found = 0;
    for (int i = 0; i < 2 * FRAME * CD; i++) begin
      @(negedge clk);
      if (cur_v() == 5 && cur_h() == HV + HF + 3) begin
        found = 1;
        break;
      end
    end
    if (!found) check("wait_mid_line", 32'd0, 32'd1);
    #2;
    check("pre_rst_hs", 32'(vga_hs), 32'd0);
    check("pre_rst_req_valid", 32'(req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_hs", 32'(vga_hs), 32'd1);
    check("async_req_valid", 32'(req_valid), 32'd1);
    check("async_x", 32'(x), 32'd0);
    check("async_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 1;
    repeat (FRAME * CD + FRAME * CD / 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
